// File: rtl/fdiv32.sv
// fdiv32 -- iterative IEEE-754 single-precision divider, result = op1 / op2.
// Radix-2 restoring division, one quotient bit per cycle. Subnormal inputs
// are read as zero and subnormal results are flushed to signed zero.
//
// Ports:
//   clk     rising-edge clock
//   rst     synchronous reset, active high
//   start   request, accepted in IDLE or DONE
//   op1     dividend (FP32)
//   op2     divisor  (FP32)
//   rmode   00 RNE, 01 RTZ, 10 toward +inf, 11 toward -inf
//   busy    operation in flight (SPEC, DIV, RND)
//   val     one-cycle pulse, result/flags valid
//   result  quotient, held until overwritten by the next operation
//   flags   {nv, dz, of, uf, nx}, held with result
module fdiv32 #(
   parameter logic [31:0] QNAN = 32'h7FC0_0000,
   parameter int          ITER = 26
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] op1,
   input  logic [31:0] op2,
   input  logic [1:0]  rmode,
   output logic        busy,
   output logic        val,
   output logic [31:0] result,
   output logic [4:0]  flags
);

   typedef enum logic [2:0] {S_IDLE, S_DIV, S_RND, S_DONE, S_SPEC} state_t;

   localparam logic [1:0] RM_RNE = 2'b00;
   localparam logic [1:0] RM_RTZ = 2'b01;
   localparam logic [1:0] RM_RUP = 2'b10;
   localparam logic [1:0] RM_RDN = 2'b11;

   state_t      state, state_nx;
   logic [31:0] a_q, b_q;
   logic [1:0]  rm_q;
   logic [25:0] rem_q;
   logic [25:0] q_q;
   logic [4:0]  cnt_q;

   // ---------------------------------------------------------------
   // Classification of the incoming operands (drives IDLE branching)
   // ---------------------------------------------------------------
   logic in_spec;
   always_comb begin
      in_spec = (op1[30:23] == 8'hFF) || (op1[30:23] == 8'h00) ||
                (op2[30:23] == 8'hFF) || (op2[30:23] == 8'h00);
   end

   logic accept;
   assign accept = start && (state == S_IDLE || state == S_DONE);

   logic div_last;
   assign div_last = (cnt_q == 5'(ITER - 1));

   // ---------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   // FSM: next state
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE, S_DONE: begin
            if (start) state_nx = in_spec ? S_SPEC : S_DIV;
            else       state_nx = S_IDLE;
         end
         S_DIV:   if (div_last) state_nx = S_RND;
         S_RND:   state_nx = S_DONE;
         S_SPEC:  state_nx = S_DONE;
         default: state_nx = S_IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      busy = (state == S_DIV) || (state == S_RND) || (state == S_SPEC);
      val  = (state == S_DONE);
   end

   // ---------------------------------------------------------------
   // Restoring division datapath
   // ---------------------------------------------------------------
   logic [25:0] m2_ext;
   logic        ge;
   logic [25:0] rem_sub;
   assign m2_ext  = {2'b00, 1'b1, b_q[22:0]};
   assign ge      = (rem_q >= m2_ext);
   assign rem_sub = ge ? (rem_q - m2_ext) : rem_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q   <= '0;
         b_q   <= '0;
         rm_q  <= '0;
         rem_q <= '0;
         q_q   <= '0;
         cnt_q <= '0;
      end else if (accept) begin
         a_q   <= op1;
         b_q   <= op2;
         rm_q  <= rmode;
         rem_q <= {2'b00, 1'b1, op1[22:0]};
         q_q   <= '0;
         cnt_q <= '0;
      end else if (state == S_DIV) begin
         // rem stays below 2*m2 < 2^25, so the shift never loses a bit
         rem_q <= {rem_sub[24:0], 1'b0};
         q_q   <= {q_q[24:0], ge};
         cnt_q <= cnt_q + 5'd1;
      end
   end

   // ---------------------------------------------------------------
   // Normalise and round
   // ---------------------------------------------------------------
   logic               sign;
   logic signed [9:0]  e_pre, e_r;
   logic [22:0]        frac, frac_r;
   logic               g, s, lsb, inc;
   logic [23:0]        frac_sum;
   logic               ovf, unf;
   logic [31:0]        rnd_res;
   logic [4:0]         rnd_flg;

   assign sign = a_q[31] ^ b_q[31];

   always_comb begin
      e_pre = $signed(10'(a_q[30:23]) - 10'(b_q[30:23]) +
                      (q_q[25] ? 10'd127 : 10'd126));
      if (q_q[25]) begin
         frac = q_q[24:2];
         g    = q_q[1];
         s    = q_q[0] | (rem_q != 26'd0);
      end else begin
         frac = q_q[23:1];
         g    = q_q[0];
         s    = (rem_q != 26'd0);
      end
      lsb = frac[0];
      case (rm_q)
         RM_RNE:  inc = g & (s | lsb);
         RM_RTZ:  inc = 1'b0;
         RM_RUP:  inc = (g | s) & ~sign;
         default: inc = (g | s) & sign;
      endcase
      frac_sum = {1'b0, frac} + 24'(inc);
      // carry out of the fraction bumps the exponent; fraction wraps to 0
      frac_r   = frac_sum[23] ? 23'd0 : frac_sum[22:0];
      e_r      = e_pre + (frac_sum[23] ? 10'sd1 : 10'sd0);
      ovf      = (e_r >= 10'sd255);
      unf      = (e_r <= 10'sd0);

      rnd_flg = {2'b00, 1'b0, 1'b0, g | s};
      rnd_res = {sign, e_r[7:0], frac_r};
      if (ovf) begin
         rnd_flg = 5'b00101;
         if ((rm_q == RM_RNE) || (rm_q == RM_RUP && !sign) ||
             (rm_q == RM_RDN && sign))
            rnd_res = {sign, 8'hFF, 23'd0};
         else
            rnd_res = {sign, 8'hFE, 23'h7FFFFF};
      end else if (unf) begin
         rnd_flg = 5'b00011;
         rnd_res = {sign, 31'd0};
      end
   end

   // ---------------------------------------------------------------
   // Special-case results (latched operands)
   // ---------------------------------------------------------------
   logic        nan1, nan2, inf1, inf2, zer1, zer2;
   logic [31:0] spc_res;
   logic [4:0]  spc_flg;

   always_comb begin
      nan1 = (a_q[30:23] == 8'hFF) && (a_q[22:0] != 23'd0);
      nan2 = (b_q[30:23] == 8'hFF) && (b_q[22:0] != 23'd0);
      inf1 = (a_q[30:23] == 8'hFF) && (a_q[22:0] == 23'd0);
      inf2 = (b_q[30:23] == 8'hFF) && (b_q[22:0] == 23'd0);
      zer1 = (a_q[30:23] == 8'h00);
      zer2 = (b_q[30:23] == 8'h00);
      spc_flg = 5'd0;
      if (nan1 || nan2) begin
         spc_res = QNAN;
      end else if ((zer1 && zer2) || (inf1 && inf2)) begin
         spc_res = QNAN;
         spc_flg = 5'b10000;
      end else if (inf1) begin
         spc_res = {sign, 8'hFF, 23'd0};
      end else if (zer2) begin
         // op1 is finite and nonzero here
         spc_res = {sign, 8'hFF, 23'd0};
         spc_flg = 5'b01000;
      end else begin
         spc_res = {sign, 31'd0};
      end
   end

   // ---------------------------------------------------------------
   // Result registers, loaded on entry to DONE
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         result <= '0;
         flags  <= '0;
      end else if (state == S_RND) begin
         result <= rnd_res;
         flags  <= rnd_flg;
      end else if (state == S_SPEC) begin
         result <= spc_res;
         flags  <= spc_flg;
      end
   end

endmodule

// File: tb/tb_fdiv32.sv
module tb_fdiv32;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] op1, op2;
   logic [1:0]  rmode;
   logic        busy, val;
   logic [31:0] result;
   logic [4:0]  flags;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   fdiv32 dut (
      .clk(clk), .rst(rst), .start(start), .op1(op1), .op2(op2),
      .rmode(rmode), .busy(busy), .val(val), .result(result), .flags(flags)
   );

   // Launch one operation and wait for val. n counts edges with the
   // accepting edge as 1; bc counts samples with busy high.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] rm, output int n, output int bc);
      @(negedge clk);
      op1 = a; op2 = b; rmode = rm; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      n = 1; bc = 0;
      while (!val && n < 100) begin
         if (busy) bc++;
         @(posedge clk); #1;
         n++;
      end
   endtask

   task automatic chk(input string nm, input logic [31:0] exp_r,
                      input logic [4:0] exp_f, input int exp_n, input int n);
      total++;
      if (result !== exp_r) begin
         bad++; $display("FAIL %s result got=%h exp=%h", nm, result, exp_r);
      end
      total++;
      if (flags !== exp_f) begin
         bad++; $display("FAIL %s flags got=%b exp=%b", nm, flags, exp_f);
      end
      total++;
      if (n != exp_n) begin
         bad++; $display("FAIL %s latency got=%0d exp=%0d", nm, n, exp_n);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; start = 1'b0; op1 = '0; op2 = '0; rmode = '0;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if ({busy, val, result, flags} !== 39'd0) begin
         bad++; $display("FAIL reset got=%b/%b/%h/%b exp=0/0/0/0", busy, val, result, flags);
      end
      @(negedge clk) rst = 1'b0;
   endtask

   task automatic test_normal;
      int n, bc;
      run_op(32'h40400000, 32'h3FC00000, 2'b00, n, bc);
      chk("3.0/1.5", 32'h40000000, 5'b00000, 28, n);
      total++;
      if (bc != 27) begin
         bad++; $display("FAIL busy_len got=%0d exp=27", bc);
      end
      @(posedge clk); #1;
      total++;
      if (val !== 1'b0 || busy !== 1'b0) begin
         bad++; $display("FAIL val_pulse got val=%b busy=%b exp=0/0", val, busy);
      end
   endtask

   task automatic test_round;
      int n, bc;
      run_op(32'h3F800000, 32'h40400000, 2'b00, n, bc);
      chk("1/3 RNE", 32'h3EAAAAAB, 5'b00001, 28, n);
      run_op(32'h3F800000, 32'h40400000, 2'b01, n, bc);
      chk("1/3 RTZ", 32'h3EAAAAAA, 5'b00001, 28, n);
      run_op(32'h3F800000, 32'h40400000, 2'b10, n, bc);
      chk("1/3 RUP", 32'h3EAAAAAB, 5'b00001, 28, n);
      run_op(32'hBF800000, 32'h40400000, 2'b10, n, bc);
      chk("-1/3 RUP", 32'hBEAAAAAA, 5'b00001, 28, n);
      run_op(32'hBF800000, 32'h40400000, 2'b11, n, bc);
      chk("-1/3 RDN", 32'hBEAAAAAB, 5'b00001, 28, n);
   endtask

   task automatic test_special;
      int n, bc;
      run_op(32'h3F800000, 32'h00000000, 2'b00, n, bc);
      chk("1/0", 32'h7F800000, 5'b01000, 2, n);
      run_op(32'h00000000, 32'h00000000, 2'b00, n, bc);
      chk("0/0", 32'h7FC00000, 5'b10000, 2, n);
      run_op(32'hFF800000, 32'h40000000, 2'b00, n, bc);
      chk("-inf/2", 32'hFF800000, 5'b00000, 2, n);
      run_op(32'h7FC12345, 32'h3F800000, 2'b00, n, bc);
      chk("nan/1", 32'h7FC00000, 5'b00000, 2, n);
      run_op(32'h3F800000, 32'hFF800000, 2'b00, n, bc);
      chk("1/-inf", 32'h80000000, 5'b00000, 2, n);
   endtask

   task automatic test_overflow;
      int n, bc;
      run_op(32'h7F000000, 32'h3E800000, 2'b00, n, bc);
      chk("ovf RNE", 32'h7F800000, 5'b00101, 28, n);
      run_op(32'h7F000000, 32'h3E800000, 2'b01, n, bc);
      chk("ovf RTZ", 32'h7F7FFFFF, 5'b00101, 28, n);
      run_op(32'hFF000000, 32'h3E800000, 2'b10, n, bc);
      chk("ovf -RUP", 32'hFF7FFFFF, 5'b00101, 28, n);
   endtask

   task automatic test_underflow;
      int n, bc;
      run_op(32'h00800000, 32'h40000000, 2'b00, n, bc);
      chk("unf +", 32'h00000000, 5'b00011, 28, n);
      run_op(32'h80800000, 32'h40000000, 2'b00, n, bc);
      chk("unf -", 32'h80000000, 5'b00011, 28, n);
   endtask

   task automatic test_busy_ignore;
      int n;
      @(negedge clk);
      op1 = 32'h40400000; op2 = 32'h3FC00000; rmode = 2'b00; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      n = 1;
      while (!val && n < 100) begin
         if (n == 10) begin
            op1 = 32'h3F800000; op2 = 32'h40400000; rmode = 2'b01; start = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         n++;
      end
      start = 1'b0;
      chk("ignore", 32'h40000000, 5'b00000, 28, n);
   endtask

   task automatic test_reset_mid;
      int seen;
      @(negedge clk);
      op1 = 32'h3F800000; op2 = 32'h40400000; rmode = 2'b00; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;
      total++;
      if (busy !== 1'b0) begin
         bad++; $display("FAIL rst_mid busy got=%b exp=0", busy);
      end
      @(negedge clk) rst = 1'b0;
      seen = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (val) seen++;
      end
      total++;
      if (seen != 0) begin
         bad++; $display("FAIL rst_mid val pulses got=%0d exp=0", seen);
      end
   endtask

   task automatic test_back_to_back;
      int n, bc;
      run_op(32'h40400000, 32'h3FC00000, 2'b00, n, bc);
      chk("b2b first", 32'h40000000, 5'b00000, 28, n);
      // still inside the DONE cycle: issue the next request now
      op1 = 32'h3F800000; op2 = 32'h40400000; rmode = 2'b00; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      n = 1;
      while (!val && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk("b2b second", 32'h3EAAAAAB, 5'b00001, 28, n);
   endtask

   initial begin
      test_reset;
      test_normal;
      test_round;
      test_special;
      test_overflow;
      test_underflow;
      test_busy_ignore;
      test_reset_mid;
      test_back_to_back;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fdiv32.md
Name: fdiv32

Overview:
- Iterative IEEE-754 single-precision divider: result = op1 / op2.
- Sits alongside the FP32 multiplier in the FP datapath and shares its operand format and rmode encoding.
- Uses radix-2 restoring division, one quotient bit per cycle, with a start/val handshake.
- Subnormal inputs are treated as zero; subnormal results are flushed to signed zero.

Parameters:
QNAN, 32'h7FC00000, canonical quiet NaN returned for every NaN or invalid result
ITER, 26, quotient bits generated: 1 integer bit plus 25 fraction bits

Ports:
clk     input   1   clock, rising edge
rst     input   1   synchronous reset, active-high
start   input   1   request; accepted when busy=0
op1     input   32  dividend, FP32
op2     input   32  divisor, FP32
rmode   input   2   00 round-to-nearest-even (RNE), 01 round-toward-zero (RTZ), 10 round-toward-+inf (RUP), 11 round-toward--inf (RDN)
busy    output  1   high while an operation is in flight
val     output  1   one-cycle pulse: result and flags are valid
result  output  32  quotient; held until the next accepted start
flags   output  5   {nv, dz, of, uf, nx}; held with result

Behaviour:
- Reset: state=IDLE; busy=0, val=0, result=0, flags=0. Reset mid-operation abandons the operation and produces no val pulse.
- States:
  - IDLE: on start, latch op1, op2 and rmode; classify both operands. Next state is SPEC if either operand is special, otherwise DIV.
  - DIV: runs ITER cycles, iteration counter 0..25.
  - RND: one cycle.
  - DONE: one cycle.
  - SPEC: one cycle.
- busy=1 in SPEC, DIV and RND; busy=0 in IDLE and DONE.
- start while busy=1 is ignored; operands are not re-latched.
- start in DONE is accepted exactly as in IDLE, giving back-to-back operation.
- val=1 only in DONE; result and flags are registered on entry to DONE.
- Latency (start accepting edge to first cycle with val=1):
  - 28 cycles for the normal path (DIV 26 + RND 1 + DONE).
  - 2 cycles for special cases.
- Classification:
  - exp=255 with mant!=0 is NaN; exp=255 with mant=0 is inf.
  - exp=0 is zero, regardless of mant.
  - All other encodings are normal, with hidden 1 added: m = {1, mant}, 24 bits.
- Sign: sign = s1 XOR s2, for every result except NaN.
- Special-case results:
  - Either operand NaN -> QNAN, nv=0.
  - 0/0 or inf/inf -> QNAN, nv=1.
  - finite nonzero / 0 -> signed inf, dz=1.
  - inf / (finite or 0) -> signed inf.
  - 0 / (nonzero) or finite / inf -> signed zero.
- Division:
  - Remainder starts at m1. Each cycle: if rem >= m2, q bit = 1 and rem -= m2; then rem <<= 1.
  - Bits are generated MSB first into q[25:0]; q[25] has weight 2^0.
  - rem width is 26 bits.
  - Quotient range: 0.5 < q < 2.
- Normalise (RND state):
  - If q[25]=1: frac=q[24:2], g=q[1], s=q[0]|(rem!=0), e=e1-e2+127.
  - Else: frac=q[23:1], g=q[0], s=(rem!=0), e=e1-e2+126.
  - e is computed as 10-bit signed.
- Round increment (lsb is the LSB of frac):
  - RNE: g & (s | lsb).
  - RTZ: 0.
  - RUP: (g|s) & ~sign.
  - RDN: (g|s) & sign.
- Rounding carry out of frac: frac=0 and e+1.
- nx = g|s, also set on overflow and underflow.
- Overflow (e >= 255): of=1, nx=1.
  - RNE -> signed inf.
  - RTZ -> signed max finite (7F7FFFFF magnitude).
  - RUP -> +inf if positive, -max if negative.
  - RDN -> -inf if negative, +max if positive.
- Underflow (e <= 0, after rounding): signed zero, uf=1, nx=1.
- flags are zero unless set by the rules above.

Test Plan:
- 3.0/1.5: op1=40400000, op2=3FC00000, rmode=00 -> result 40000000, flags 0; val exactly 28 cycles after start; busy high for 27 cycles.
- 1.0/3.0: op1=3F800000, op2=40400000 -> RNE gives 3EAAAAAB, flags 00001; RTZ gives 3EAAAAAA, flags 00001.
- Special cases, each with val 2 cycles after start:
  - 1.0/0.0 -> 7F800000, dz=1.
  - 0/0 -> 7FC00000, nv=1.
  - FF800000/40000000 -> FF800000, flags 0.
- Overflow: 7F000000/3E800000 -> RNE gives 7F800000, flags 00101; RTZ gives 7F7FFFFF; op1 with sign flipped (FF000000) under RUP gives FF7FFFFF.
- Underflow: 00800000/40000000 -> 00000000, flags 00011; sign preserved when op1=80800000.
- Control:
  - start pulsed at cycle 10 of DIV with other operands -> ignored, first result is unchanged.
  - rst at DIV cycle 5 -> busy=0 next cycle and no val pulse.
  - start asserted in the DONE cycle -> accepted; second val 28 cycles later.
